// File: rtl/syn_weight_sched.sv
// Synaptic weight scheduler: scans a 64-row weight RAM once per start, summing the weights of
// spiking presynaptic rows into a saturating current, and arbitrates host writes against the scan.
module syn_weight_sched #(
    parameter int NEURON_ADR = 5,
    parameter int WEIGHTS    = 10,
    parameter int ACC_W      = 18
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [2**(NEURON_ADR+1)-1:0]      spike_vec,
    output logic                              busy,
    output logic                              done,
    output logic signed [ACC_W-1:0]           i_syn,
    output logic                              sat,
    input  logic                              cfg_req,
    input  logic [NEURON_ADR:0]               cfg_addr,
    input  logic [WEIGHTS:0]                  cfg_data,
    output logic                              cfg_ack,
    output logic                              ram_we,
    output logic [NEURON_ADR:0]               ram_a,
    output logic [WEIGHTS:0]                  ram_di,
    output logic [NEURON_ADR:0]               ram_dpra,
    input  logic [WEIGHTS:0]                  ram_dpo
);
    localparam int AW    = NEURON_ADR + 1;
    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                  state_q;
    logic [DEPTH-1:0]        spk_q;
    logic [AW-1:0]           idx_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, i_syn_q;
    logic                    sat_run_q, sat_run_d, sat_q, busy_q, done_q;

    logic signed [ACC_W:0]   sum;
    logic                    ovf;
    logic                    hit;

    // One extra guard bit: an overflow shows up as the top two bits disagreeing.
    always_comb begin
        hit       = spk_q[idx_q];
        sum       = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-WEIGHTS){ram_dpo[WEIGHTS]}}, ram_dpo};
        ovf       = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d     = acc_q;
        sat_run_d = sat_run_q;
        if (hit) begin
            sat_run_d = sat_run_q | ovf;
            if (!ovf)
                acc_d = sum[ACC_W-1:0];
            else if (sum[ACC_W])
                acc_d = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_d = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            spk_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            sat_run_q <= 1'b0;
            i_syn_q   <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    spk_q     <= spike_vec;
                    acc_q     <= '0;
                    sat_run_q <= 1'b0;
                    idx_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= SCAN;
                end
                SCAN: begin
                    acc_q     <= acc_d;
                    sat_run_q <= sat_run_d;
                    // Index parks on the last row rather than wrapping.
                    if (idx_q == AW'(DEPTH-1)) begin
                        i_syn_q <= acc_d;
                        sat_q   <= sat_run_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Writes only land while idle, so a run always sees one consistent weight set.
    assign cfg_ack  = cfg_req & (state_q == IDLE);
    assign ram_we   = cfg_ack;
    assign ram_a    = cfg_addr;
    assign ram_di   = cfg_data;
    assign ram_dpra = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign i_syn    = i_syn_q;
    assign sat      = sat_q;
endmodule

// File: tb/tb_syn_weight_sched.sv
// Scoreboard bench for syn_weight_sched: a default instance and an ACC_W=12 instance run the
// same stimulus against a reference sum computed from a weight array kept in the bench.
module tb_syn_weight_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [63:0] spike_vec = '0;
    logic cfg_req = 1'b0;
    logic [5:0] cfg_addr = '0;
    logic [10:0] cfg_data = '0;

    logic busy0, done0, sat0, ack0, we0, busy1, done1, sat1, ack1, we1;
    logic signed [17:0] isyn0;
    logic signed [11:0] isyn1;
    logic [5:0] a0, dpra0, a1, dpra1;
    logic [10:0] di0, dpo0, di1, dpo1;
    logic [10:0] ram0 [64];
    logic [10:0] ram1 [64];

    syn_weight_sched dut0 (.clk(clk), .rst_n(rst_n), .start(start), .spike_vec(spike_vec),
        .busy(busy0), .done(done0), .i_syn(isyn0), .sat(sat0), .cfg_req(cfg_req),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(ack0), .ram_we(we0), .ram_a(a0),
        .ram_di(di0), .ram_dpra(dpra0), .ram_dpo(dpo0));
    syn_weight_sched #(.ACC_W(12)) dut1 (.clk(clk), .rst_n(rst_n), .start(start),
        .spike_vec(spike_vec), .busy(busy1), .done(done1), .i_syn(isyn1), .sat(sat1),
        .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(ack1),
        .ram_we(we1), .ram_a(a1), .ram_di(di1), .ram_dpra(dpra1), .ram_dpo(dpo1));

    assign dpo0 = ram0[dpra0];
    assign dpo1 = ram1[dpra1];
    always @(posedge clk) begin
        if (we0) ram0[a0] <= di0;
        if (we1) ram1[a1] <= di1;
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int is0; bit s0; int is1; bit s1;} exp_t;
    exp_t sb[$];
    int mem_model [64];
    int run_p = -1000;
    int exp_is0 = 0, exp_is1 = 0;
    bit exp_s0 = 0, exp_s1 = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: walk the rows in order, clamping after every added weight.
    task automatic model(input logic [63:0] spk, input int accw, output int s, output bit st);
        int hi, lo;
        hi = (1 << (accw - 1)) - 1;
        lo = -(1 << (accw - 1));
        s = 0; st = 0;
        for (int i = 0; i < 64; i++) begin
            if (spk[i]) begin
                s = s + mem_model[i];
                if (s > hi) begin s = hi; st = 1; end
                if (s < lo) begin s = lo; st = 1; end
            end
        end
    endtask

    always @(negedge clk) begin
        bit eb;
        exp_t e;
        eb = (cyc >= run_p) && (cyc <= run_p + 64);
        chk("busy", busy0, eb);
        chk("busy_acc12", busy1, eb);
        chk("done", done0, cyc == run_p + 64);
        chk("done_acc12", done1, cyc == run_p + 64);
        chk("ram_we", we0, cfg_req && !eb);
        chk("cfg_ack", ack0, cfg_req && !eb);
        chk("ram_we_acc12", we1, cfg_req && !eb);
        if (we0) begin
            chk("ram_a", a0, cfg_addr);
            chk("ram_di", di0, cfg_data);
        end
        if (eb && cyc <= run_p + 63) chk("ram_dpra", dpra0, cyc - run_p);
        if (done0) begin
            if (sb.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                exp_is0 = e.is0; exp_s0 = e.s0; exp_is1 = e.is1; exp_s1 = e.s1;
            end
        end
        chk("i_syn", int'(isyn0), exp_is0);
        chk("sat", sat0, exp_s0);
        chk("i_syn_acc12", int'(isyn1), exp_is1);
        chk("sat_acc12", sat1, exp_s1);
    end

    task automatic push_exp(input logic [63:0] spk);
        exp_t e;
        model(spk, 18, e.is0, e.s0);
        model(spk, 12, e.is1, e.s1);
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        while (cyc < run_p + 65) begin @(posedge clk); #1; end
    endtask

    task automatic cfg_write(input int a, input int d, output int ack_cyc);
        int n;
        n = 0;
        cfg_req = 1'b1; cfg_addr = a[5:0]; cfg_data = d[10:0];
        @(negedge clk);
        while (!ack0 && n < 200) begin @(negedge clk); n++; end
        ack_cyc = cyc;
        if (!ack0) chk("cfg_ack_timeout", 0, 1);
        else mem_model[a] = d;
        @(posedge clk); #1;
        cfg_req = 1'b0;
    endtask

    task automatic load_all(input int base, input int step);
        int ac;
        for (int i = 0; i < 64; i++) cfg_write(i, base + step * i, ac);
    endtask

    task automatic start_run(input logic [63:0] spk, input bit dow, input int wa, input int wd);
        start = 1'b1; spike_vec = spk;
        if (dow) begin cfg_req = 1'b1; cfg_addr = wa[5:0]; cfg_data = wd[10:0]; end
        @(negedge clk);
        if (dow) begin
            chk("cfg_ack_with_start", ack0, 1);
            mem_model[wa] = wd;
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_req = 1'b0;
        run_p = cyc;
        push_exp(spk);
    endtask

    function automatic int rnd_w();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 1023;
        if (k == 1) return -1024;
        return $urandom_range(0, 2047) - 1024;
    endfunction

    initial begin
        int ac, p, nw;
        logic [63:0] spk;
        for (int i = 0; i < 64; i++) mem_model[i] = 0;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_i_syn", int'(isyn0), 0);
        chk("rst_sat", sat0, 0);
        chk("rst_dpra", dpra0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // all-zero RAM so the monitor's read-data path is well defined
        load_all(0, 0);

        load_all(1, 0);
        start_run('1, 0, 0, 0);
        wait_idle();

        load_all(-32, 1);
        start_run(64'h8000_0000_0000_0001, 0, 0, 0);
        wait_idle();

        cfg_write(5, 3, ac);
        start_run(64'h20, 1, 5, -7);
        wait_idle();

        start_run(64'h20, 0, 0, 0);
        p = run_p;
        repeat (9) begin @(posedge clk); #1; end
        cfg_write(5, 100, ac);
        chk("ack_after_scan", ac, p + 65);
        start_run(64'h20, 0, 0, 0);
        wait_idle();

        load_all(1023, 0);
        start_run('1, 0, 0, 0);
        wait_idle();
        start_run(64'h1, 0, 0, 0);
        wait_idle();

        for (int r = 0; r < 24; r++) begin
            wait_idle();
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) cfg_write($urandom_range(0, 63), rnd_w(), ac);
            spk = {$urandom, $urandom};
            if (r % 4 == 0) spk = spk & {$urandom, $urandom};
            if (r % 4 == 3) spk = '1;
            start_run(spk, $urandom_range(0, 1) == 1, $urandom_range(0, 63), rnd_w());
            spike_vec = {$urandom, $urandom};
            if (r % 5 == 2) begin
                repeat ($urandom_range(1, 50)) begin @(posedge clk); #1; end
                cfg_write($urandom_range(0, 63), rnd_w(), ac);
            end
            if (r % 5 == 4) begin
                repeat (20) begin @(posedge clk); #1; end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_idle();

        // start held across DONE is re-accepted in the next idle cycle
        spk = {$urandom, $urandom};
        start = 1'b1; spike_vec = spk;
        @(posedge clk); #1;
        run_p = cyc; push_exp(spk);
        repeat (65) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_start_reaccept", cyc - run_p, 66);
        run_p = cyc; push_exp(spk);
        wait_idle();

        start_run('1, 0, 0, 0);
        repeat (29) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        sb.delete(); run_p = -1000;
        exp_is0 = 0; exp_is1 = 0; exp_s0 = 0; exp_s1 = 0;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_i_syn", int'(isyn0), 0);
        chk("midrst_sat", sat0, 0);
        chk("midrst_dpra", dpra0, 0);
        chk("midrst_i_syn_acc12", int'(isyn1), 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_run({$urandom, $urandom}, 0, 0, 0);
        wait_idle();

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
